// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: register/word widths,
// requester indices and the round-robin pointer helper.
// Optional feature macro used by the top: WB_BYPASS_EN.

`ifndef LEN_REG_ADDR
`define LEN_REG_ADDR 5
`endif

`ifndef LEN_WORD
`define LEN_WORD 32
`endif

package reg_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W  = `LEN_REG_ADDR;
  localparam int unsigned WORD_W      = `LEN_WORD;
  localparam int unsigned NUM_REGS    = 1 << REG_ADDR_W;

  // Writeback requester indices
  localparam int unsigned REQ_ALU     = 0;
  localparam int unsigned REQ_FPU     = 1;
  localparam int unsigned REQ_MEM     = 2;
  localparam int unsigned NUM_REQ_DEF = 3;

  // Pointer wide enough for up to four requesters
  localparam int unsigned PTR_W       = 2;

  // Next round-robin position after a grant to idx, wrapping at n.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx,
                                               input int unsigned n);
    if (idx == PTR_W'(n - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Round-robin grant: search starts at ptr and wraps; first valid request wins.

module rr_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Scan requesters in priority order starting from the pointer
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % int'(N));
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter with register scoreboard.
// Arbitrates ALU/FPU/MEM writebacks onto a single register-file write port
// (one cycle latency) and tracks pending destinations to raise stall.
// Optional macro WB_BYPASS_EN adds forwarding of the granted write to the
// two issue read ports and masks the matching stall terms.

module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]      req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                iss_valid,
  input  logic [REG_ADDR_W-1:0]               iss_rd,
  input  logic [REG_ADDR_W-1:0]               ars1,
  input  logic [REG_ADDR_W-1:0]               ars2,
  output logic                                stall,
  output logic [REG_ADDR_W-1:0]               ard,
  output logic [WORD_W-1:0]                   drd
`ifdef WB_BYPASS_EN
  ,
  output logic                                fwd1_hit,
  output logic [WORD_W-1:0]                   fwd1_data,
  output logic                                fwd2_hit,
  output logic [WORD_W-1:0]                   fwd2_data
`endif
);

  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      w_ptr_d;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_any;
  logic [PTR_W-1:0]      w_gidx;
  logic [REG_ADDR_W-1:0] w_gaddr;
  logic [WORD_W-1:0]     w_gdata;
  logic [NUM_REGS-1:0]   r_busy;
  logic [NUM_REGS-1:0]   w_busy_d;
  logic [REG_ADDR_W-1:0] r_ard;
  logic [WORD_W-1:0]     r_drd;
  logic                  w_t1;
  logic                  w_t2;
  logic                  w_t3;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  // Grants are suppressed while reset is held so req_ready reads all-zero
  assign w_grant   = rstn ? w_gnt : '0;
  assign req_ready = w_grant;

  // Encode the one-hot grant and select the winning address/data
  always_comb begin
    w_any   = 1'b0;
    w_gidx  = '0;
    w_gaddr = '0;
    w_gdata = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_grant[i]) begin
        w_any   = 1'b1;
        w_gidx  = PTR_W'(i);
        w_gaddr = req_addr[i];
        w_gdata = req_data[i];
      end
    end
  end

  assign w_ptr_d = w_any ? rr_next(w_gidx, NUM_REQ) : r_ptr;

  // Scoreboard next state: clear on writeback, then set on issue so set wins
  always_comb begin
    w_busy_d = r_busy;
    if (w_any) begin
      w_busy_d[w_gaddr] = 1'b0;
    end
    if (iss_valid) begin
      w_busy_d[iss_rd] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  // Pointer, scoreboard and registered write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr  <= '0;
      r_busy <= '0;
      r_ard  <= '0;
      r_drd  <= '0;
    end else begin
      r_ptr  <= w_ptr_d;
      r_busy <= w_busy_d;
      r_ard  <= w_any ? w_gaddr : '0;
      r_drd  <= w_any ? w_gdata : '0;
    end
  end

  assign ard = r_ard;
  assign drd = r_drd;

  // Hazard terms: source reads (RAW) and destination reuse (WAW)
  assign w_t1 = (ars1 != '0) && r_busy[ars1];
  assign w_t2 = (ars2 != '0) && r_busy[ars2];
  assign w_t3 = (iss_rd != '0) && r_busy[iss_rd];

`ifdef WB_BYPASS_EN
  assign fwd1_hit  = w_any && (ars1 != '0) && (w_gaddr == ars1);
  assign fwd2_hit  = w_any && (ars2 != '0) && (w_gaddr == ars2);
  assign fwd1_data = fwd1_hit ? w_gdata : '0;
  assign fwd2_data = fwd2_hit ? w_gdata : '0;
  // A forwarded source no longer needs to wait for the register file
  assign stall     = (w_t1 && !fwd1_hit) || (w_t2 && !fwd2_hit) || w_t3;
`else
  assign stall     = w_t1 || w_t2 || w_t3;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: behavioural model compared every
// cycle, plus directed scenarios with literal expectations.

module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  localparam int unsigned NUM_REQ = 3;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                               clk;
  logic                               rstn;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][WORD_W-1:0]     req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               iss_valid;
  logic [REG_ADDR_W-1:0]              iss_rd;
  logic [REG_ADDR_W-1:0]              ars1;
  logic [REG_ADDR_W-1:0]              ars2;
  logic                               stall;
  logic [REG_ADDR_W-1:0]              ard;
  logic [WORD_W-1:0]                  drd;
`ifdef WB_BYPASS_EN
  logic                               fwd1_hit;
  logic [WORD_W-1:0]                  fwd1_data;
  logic                               fwd2_hit;
  logic [WORD_W-1:0]                  fwd2_data;
`endif

  int errors = 0;
  int checks = 0;

  reg_wb_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .ars1      (ars1),
    .ars2      (ars2),
    .stall     (stall),
    .ard       (ard),
    .drd       (drd)
`ifdef WB_BYPASS_EN
    ,
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                    m_ptr;
  bit [NUM_REGS-1:0]     m_busy;
  logic [REG_ADDR_W-1:0] m_ard;
  logic [WORD_W-1:0]     m_drd;
  int                    m_g;

  // Requester that wins this cycle: first valid one at or after the pointer.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  assign m_g = rstn ? pick(req_valid, m_ptr) : -1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ptr  <= 0;
      m_busy <= '0;
      m_ard  <= '0;
      m_drd  <= '0;
    end else begin
      m_ard <= '0;
      m_drd <= '0;
      if (m_g >= 0) begin
        m_ptr                 <= (m_g + 1) % NUM_REQ;
        m_ard                 <= req_addr[m_g];
        m_drd                 <= req_data[m_g];
        m_busy[req_addr[m_g]] <= 1'b0;
      end
      if (iss_valid && iss_rd != '0) m_busy[iss_rd] <= 1'b1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [NUM_REQ-1:0]    er;
    logic [REG_ADDR_W-1:0] ga;
    logic [WORD_W-1:0]     gd;
    logic                  h1, h2, es;
    ga = (m_g >= 0) ? req_addr[m_g] : '0;
    gd = (m_g >= 0) ? req_data[m_g] : '0;
    er = (m_g >= 0) ? (NUM_REQ'(1) << m_g) : '0;
    h1 = BYP && (m_g >= 0) && (ars1 != '0) && (ga == ars1);
    h2 = BYP && (m_g >= 0) && (ars2 != '0) && (ga == ars2);
    es = ((ars1 != '0) && m_busy[ars1] && !h1) ||
         ((ars2 != '0) && m_busy[ars2] && !h2) ||
         ((iss_rd != '0) && m_busy[iss_rd]);
    check("model_ready", req_ready, er);
    check("model_stall", stall, es);
    check("model_ard", ard, m_ard);
    if (m_ard != '0 || !rstn) check("model_drd", drd, m_drd);
`ifdef WB_BYPASS_EN
    check("model_fwd1_hit", fwd1_hit, h1);
    check("model_fwd2_hit", fwd2_hit, h2);
    check("model_fwd1_data", fwd1_data, h1 ? gd : '0);
    check("model_fwd2_data", fwd2_data, h2 ? gd : '0);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    ars1      = '0;
    ars2      = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ard", ard, 0);
      check("idle_stall", stall, 0);
      check("idle_ready", req_ready, 0);
    end
    tick();

    // RAW on r5, cleared by a MEM writeback
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0; iss_rd = '0; ars1 = 5'd5;
    @(negedge clk);
    check("raw_stall", stall, 1);
    tick();
    req_valid = 3'b100; req_addr[REQ_MEM] = 5'd5; req_data[REQ_MEM] = 32'hDEADBEEF;
    @(negedge clk);
    check("mem_ready", req_ready, 3'b100);
`ifndef WB_BYPASS_EN
    check("raw_stall_grant", stall, 1);
`endif
    tick();
    req_valid = '0;
    @(negedge clk);
    check("mem_ard", ard, 5);
    check("mem_drd", drd, 32'hDEADBEEF);
    check("raw_stall_clear", stall, 0);
    tick();
    ars1 = '0;

    // Round robin with all three held valid
    req_addr[REQ_ALU] = 5'd1; req_data[REQ_ALU] = 32'h101;
    req_addr[REQ_FPU] = 5'd2; req_data[REQ_FPU] = 32'h102;
    req_addr[REQ_MEM] = 5'd3; req_data[REQ_MEM] = 32'h103;
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_gnt", req_ready, 64'(1) << (k % 3));
      if (k > 0) check("rr_ard", ard, ((k - 1) % 3) + 1);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    check("rr_ard_last", ard, 1);
    check("rr_drd_last", drd, 32'h101);
    tick();

    // Issue and writeback of r7 in the same cycle: busy stays set
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    req_valid = 3'b001; req_addr[REQ_ALU] = 5'd7; req_data[REQ_ALU] = 32'h77; ars2 = 5'd7;
    @(negedge clk);
    check("waw_ready", req_ready, 3'b001);
    check("waw_stall_grant", stall, 1);
    tick();
    iss_valid = 1'b0; iss_rd = '0; req_valid = '0;
    @(negedge clk);
    check("waw_ard", ard, 7);
    check("waw_busy_kept", stall, 1);
    tick();
    req_valid = 3'b010; req_addr[REQ_FPU] = 5'd7;
    @(negedge clk);
    check("waw_clear_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("waw_cleared", stall, 0);
    tick();
    ars2 = '0;

    // Writes and issues to r0
    req_valid = 3'b001; req_addr[REQ_ALU] = 5'd0; req_data[REQ_ALU] = 32'h1234;
    iss_valid = 1'b1; iss_rd = 5'd0;
    @(negedge clk);
    check("r0_ready", req_ready, 3'b001);
    check("r0_stall", stall, 0);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("r0_ard", ard, 0);
    check("r0_stall_next", stall, 0);
    tick();
    iss_valid = 1'b0;

`ifdef WB_BYPASS_EN
    // Forward the granted ALU write of r9 to ars1
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0; iss_rd = '0; ars1 = 5'd9;
    req_valid = 3'b001; req_addr[REQ_ALU] = 5'd9; req_data[REQ_ALU] = 32'h55;
    @(negedge clk);
    check("byp_hit", fwd1_hit, 1);
    check("byp_data", fwd1_data, 32'h55);
    check("byp_stall", stall, 0);
    tick();
    req_valid = '0; ars1 = '0;
`endif

    // Reset while a transfer is being granted
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0; iss_rd = '0; ars1 = 5'd4;
    req_valid = 3'b010; req_addr[REQ_FPU] = 5'd3; req_data[REQ_FPU] = 32'hCAFE;
    @(negedge clk);
    check("rst_pre_stall", stall, 1);
    check("rst_pre_ready", req_ready, 3'b010);
    #1 rstn = 1'b0;
    #1;
    check("rst_ard", ard, 0);
    check("rst_drd", drd, 0);
    check("rst_ready", req_ready, 0);
    check("rst_stall", stall, 0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("rst_no_write", ard, 0);
    check("rst_regrant", req_ready, 3'b010);
    tick();
    req_valid = '0; ars1 = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
